hazard_ctrl: RTL and testbench

Pipeline hazard and fetch-stall controller for the 5-stage CPU; it produces the `IF_ID_write`/`IF_ID_flush` controls consumed by the IF/ID pipeline register, plus PC-write and ID/EX bubble controls. It detects load-use hazards, applies taken-branch/jump flushes, and sequences instruction-memory wait states through a small FSM. It also discards wrong-path fetches that are still in flight when a redirect occurs. Optional saturating performance counters report stall and flush cycles.

---
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and fetch-stall controller: load-use bubbles, redirect flushes, and imem wait-state sequencing.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ID_EX_MemRead_i,
    input  logic [4:0]  ID_EX_RDaddr_i,
    input  logic [4:0]  IF_ID_RSaddr_i,
    input  logic [4:0]  IF_ID_RTaddr_i,
    input  logic        redirect_i,
    input  logic        imem_ready_i,
    output logic        PC_write_o,
    output logic        IF_ID_write_o,
    output logic        IF_ID_flush_o,
    output logic        ID_EX_bubble_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] IMISS   = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0] state_q, state_d;
    logic       loadUse;
    logic       pcWrite;
    logic       ifIdWrite;
    logic       ifIdFlush;
    logic       idExBubble;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign loadUse = ID_EX_MemRead_i && (ID_EX_RDaddr_i != 5'd0) &&
                     ((ID_EX_RDaddr_i == IF_ID_RSaddr_i) ||
                      (ID_EX_RDaddr_i == IF_ID_RTaddr_i));

    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b0;
        idExBubble = 1'b0;
        state_d    = state_q;
        case (state_q)
            RUN: begin
                if (loadUse) begin
                    pcWrite    = 1'b0;
                    ifIdWrite  = 1'b0;
                    idExBubble = 1'b1;
                end else if (redirect_i) begin
                    ifIdFlush = 1'b1;
                    state_d   = imem_ready_i ? RUN : DISCARD;
                end else if (!imem_ready_i) begin
                    pcWrite   = 1'b0;
                    ifIdFlush = 1'b1;
                    state_d   = IMISS;
                end
            end
            IMISS: begin
                if (!imem_ready_i) begin
                    pcWrite   = 1'b0;
                    ifIdFlush = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            DISCARD: begin
                // The word still in flight belongs to the wrong path, so it is dropped even when ready.
                pcWrite   = 1'b0;
                ifIdFlush = 1'b1;
                if (imem_ready_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                pcWrite   = 1'b0;
                ifIdFlush = 1'b1;
                state_d   = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign PC_write_o     = rst_i ? 1'b0 : pcWrite;
    assign IF_ID_write_o  = rst_i ? 1'b1 : ifIdWrite;
    assign IF_ID_flush_o  = rst_i ? 1'b1 : ifIdFlush;
    assign ID_EX_bubble_o = rst_i ? 1'b1 : idExBubble;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pcWrite && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (ifIdFlush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 16'h0000;
    assign flush_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        memRead;
    logic [4:0]  rdAddr;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic        redirect;
    logic        ready;
    logic        pcWrite;
    logic        ifIdWrite;
    logic        ifIdFlush;
    logic        idExBubble;
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;
    logic [3:0]  ctrlVec;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [15:0] expStall   = 16'h0000;
    logic [15:0] expFlush   = 16'h0000;

    hazard_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ID_EX_MemRead_i (memRead),
        .ID_EX_RDaddr_i  (rdAddr),
        .IF_ID_RSaddr_i  (rsAddr),
        .IF_ID_RTaddr_i  (rtAddr),
        .redirect_i      (redirect),
        .imem_ready_i    (ready),
        .PC_write_o      (pcWrite),
        .IF_ID_write_o   (ifIdWrite),
        .IF_ID_flush_o   (ifIdFlush),
        .ID_EX_bubble_o  (idExBubble),
        .stall_cnt_o     (stallCnt),
        .flush_cnt_o     (flushCnt)
    );

    assign ctrlVec = {pcWrite, ifIdWrite, ifIdFlush, idExBubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] cntExp(input logic [15:0] v);
`ifdef HAZARD_PERF_CNT_EN
        return v;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic redir, input logic rdy);
        memRead  = mr;
        rdAddr   = rd;
        rsAddr   = rs;
        rtAddr   = rt;
        redirect = redir;
        ready    = rdy;
        #3;
    endtask

    // One clock step: drive, check controls mid-cycle, clock, then advance the counter model.
    task automatic runStep(input string tag, input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                           input logic [4:0] rt, input logic redir, input logic rdy, input logic [3:0] expCtrl);
        applyStimulus(mr, rd, rs, rt, redir, rdy);
        checkOutput(tag, {12'h000, ctrlVec}, {12'h000, expCtrl});
        @(posedge clk);
        #1;
        if (!expCtrl[3]) expStall = satInc(expStall);
        if (expCtrl[1])  expFlush = satInc(expFlush);
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_stall"}, stallCnt, cntExp(expStall));
        checkOutput({tag, "_flush"}, flushCnt, cntExp(expFlush));
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        checkOutput("reset_ctrl", {12'h000, ctrlVec}, 16'h0007);
        checkOutput("reset_stall", stallCnt, 16'h0000);
        checkOutput("reset_flush", flushCnt, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        runStep("lu_rs",        1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 4'b0001);
        runStep("lu_release",   1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 4'b1100);
        checkCounters("after_lu");
        runStep("rd0_mask",     1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'b1100);
        runStep("lu_rt_redir",  1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 4'b0001);
        runStep("redir_ready",  1'b0, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 4'b1110);
        checkCounters("after_redir");

        runStep("miss_enter",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b0110);
        runStep("miss_lu_ign",  1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 4'b0110);
        runStep("miss_wait",    1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 4'b0110);
        runStep("miss_ready",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'b1100);
        checkCounters("after_miss");

        runStep("redir_busy",   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 4'b1110);
        runStep("disc_wait1",   1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 4'b0110);
        runStep("disc_wait2",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b0110);
        runStep("disc_ready",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'b0110);
        runStep("disc_exit",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'b1100);
        checkCounters("after_disc");

        runStep("miss2_enter",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b0110);
        applyStimulus(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
        checkOutput("miss2_hold", {12'h000, ctrlVec}, 16'h0006);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_ctrl", {12'h000, ctrlVec}, 16'h0007);
        checkOutput("async_rst_stall", stallCnt, 16'h0000);
        checkOutput("async_rst_flush", flushCnt, 16'h0000);
        expStall = 16'h0000;
        expFlush = 16'h0000;
        @(posedge clk);
        #1;
        rst = 1'b0;

        runStep("post_rst_lu",  1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 4'b0001);
        runStep("post_rst_adv", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'b1100);
        checkCounters("post_rst");

        runStep("sat_enter",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b0110);
        for (int i = 0; i < 65539; i++) begin
            @(posedge clk);
            expStall = satInc(expStall);
            expFlush = satInc(expFlush);
        end
        #1;
        checkOutput("sat_ctrl", {12'h000, ctrlVec}, 16'h0006);
        checkCounters("sat_hold");
        runStep("sat_exit",     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'b1100);
        checkCounters("sat_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
